// File: rtl/br_predict_unit.sv
// Branch prediction/resolution unit: direct-mapped BTB with 2-bit counters,
// resolve-time return-address stack, and a registered mispredict/redirect path.
module br_predict_unit #(
  parameter int         ADDR_W    = 32,
  parameter int         BHT_DEPTH = 64,
  parameter int         RAS_DEPTH = 4,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_pc,
  output logic              p_valid,
  output logic              p_taken,
  output logic [ADDR_W-1:0] p_target,
  input  logic              r_valid,
  input  logic [ADDR_W-1:0] r_pc,
  input  logic              r_is_br,
  input  logic              r_is_call,
  input  logic              r_is_ret,
  input  logic              r_taken,
  input  logic [ADDR_W-1:0] r_target,
  input  logic              r_pred_taken,
  input  logic [ADDR_W-1:0] r_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       mp_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int RP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RC_W  = $clog2(RAS_DEPTH + 1);

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic              valid_q [BHT_DEPTH];
  logic [1:0]        ctr_q   [BHT_DEPTH];
  logic [TAG_W-1:0]  tag_q   [BHT_DEPTH];
  logic [ADDR_W-1:0] tgt_q   [BHT_DEPTH];
  logic              is_ret_q[BHT_DEPTH];
  logic [ADDR_W-1:0] ras_mem_q[RAS_DEPTH];
  logic [RP_W-1:0]   ras_ptr_q, ras_ptr_d;
  logic [RC_W-1:0]   ras_cnt_q, ras_cnt_d;

  logic              p_valid_q, p_valid_d, p_taken_q, p_taken_d;
  logic [ADDR_W-1:0] p_target_q, p_target_d;
  logic              mispredict_q, mispredict_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [15:0]       mp_count_q, mp_count_d;

  logic [IDX_W-1:0]  f_idx, r_idx;
  logic [TAG_W-1:0]  f_tag, r_tag;
  logic              f_hit, r_hit, r_act;
  logic [ADDR_W-1:0] r_pc4, ras_top;
  logic [RP_W-1:0]   ras_top_ptr, ras_inc_ptr, ras_wptr;
  logic              ras_we, ras_empty;
  logic              ent_we, ctr_we;
  logic [1:0]        ctr_d;
  logic              mp_det;

  assign f_idx = f_pc[IDX_W+1:2];
  assign f_tag = f_pc[ADDR_W-1:IDX_W+2];
  assign r_idx = r_pc[IDX_W+1:2];
  assign r_tag = r_pc[ADDR_W-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign r_act = r_valid && reset_n;
  assign r_pc4 = r_pc + ADDR_W'(4);

  // Circular stack: ras_ptr_q is the next free slot, top is the slot below it.
  assign ras_top_ptr = (ras_ptr_q == '0) ? RP_W'(RAS_DEPTH - 1) : ras_ptr_q - 1'b1;
  assign ras_inc_ptr = (ras_ptr_q == RP_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + 1'b1;
  assign ras_top     = ras_mem_q[ras_top_ptr];
  assign ras_empty   = (ras_cnt_q == '0);

  always_comb begin
    p_valid_d  = f_valid;
    p_taken_d  = 1'b0;
    p_target_d = '0;
    if (f_valid) begin
      p_target_d = f_pc + ADDR_W'(4);
      if (f_hit && (ctr_q[f_idx][1] || is_ret_q[f_idx])) begin
        p_taken_d  = 1'b1;
        p_target_d = (is_ret_q[f_idx] && !ras_empty) ? ras_top : tgt_q[f_idx];
      end
    end
  end

  // Taken resolves always (re)write the entry; hits also retrain the counter.
  always_comb begin
    ent_we = r_act && r_taken;
    ctr_we = r_act && (r_hit || r_taken);
    ctr_d  = ctr_q[r_idx];
    if (r_hit) begin
      ctr_d = r_taken ? ctr_inc(ctr_q[r_idx]) : ctr_dec(ctr_q[r_idx]);
    end else begin
      ctr_d = 2'b10;
    end
    if (!r_is_br) begin
      ctr_d = 2'b11;
    end
  end

  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_we    = 1'b0;
    ras_wptr  = ras_ptr_q;
    if (r_act && r_is_call && r_taken && r_is_ret) begin
      ras_we   = 1'b1;
      ras_wptr = ras_top_ptr;
    end else if (r_act && r_is_call && r_taken) begin
      ras_we    = 1'b1;
      ras_ptr_d = ras_inc_ptr;
      if (ras_cnt_q != RC_W'(RAS_DEPTH)) begin
        ras_cnt_d = ras_cnt_q + 1'b1;
      end
    end else if (r_act && r_is_ret && !ras_empty) begin
      ras_ptr_d = ras_top_ptr;
      ras_cnt_d = ras_cnt_q - 1'b1;
    end
  end

  always_comb begin
    mp_det        = r_valid && ((r_taken != r_pred_taken) ||
                                (r_taken && (r_target != r_pred_target)));
    mispredict_d  = mp_det;
    redirect_pc_d = redirect_pc_q;
    mp_count_d    = mp_count_q;
    if (mp_det) begin
      redirect_pc_d = r_taken ? r_target : r_pc4;
      if (mp_count_q != 16'hFFFF) begin
        mp_count_d = mp_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
      ras_ptr_q     <= '0;
      ras_cnt_q     <= '0;
      p_valid_q     <= 1'b0;
      p_taken_q     <= 1'b0;
      p_target_q    <= '0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      mp_count_q    <= '0;
    end else begin
      if (ent_we) valid_q[r_idx] <= 1'b1;
      if (ctr_we) ctr_q[r_idx] <= ctr_d;
      ras_ptr_q     <= ras_ptr_d;
      ras_cnt_q     <= ras_cnt_d;
      p_valid_q     <= p_valid_d;
      p_taken_q     <= p_taken_d;
      p_target_q    <= p_target_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      mp_count_q    <= mp_count_d;
    end
  end

  // Payload storage carries no reset; valid bits and stack count qualify it.
  always_ff @(posedge clk) begin
    if (ent_we) begin
      tag_q[r_idx]    <= r_tag;
      tgt_q[r_idx]    <= r_target;
      is_ret_q[r_idx] <= r_is_ret;
    end
    if (ras_we) ras_mem_q[ras_wptr] <= r_pc4;
  end

  assign p_valid     = p_valid_q;
  assign p_taken     = p_taken_q;
  assign p_target    = p_target_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign mp_count    = mp_count_q;

endmodule

// File: tb/tb_br_predict_unit.sv
// Directed bench for br_predict_unit: BTB training, RAS behaviour, aliasing,
// read-before-write lookups and reset during a resolve.
module tb_br_predict_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        p_valid, p_taken;
  logic [31:0] p_target;
  logic        r_valid, r_is_br, r_is_call, r_is_ret, r_taken, r_pred_taken;
  logic [31:0] r_pc, r_target, r_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] mp_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  br_predict_unit #(.ADDR_W(32), .BHT_DEPTH(64), .RAS_DEPTH(4), .CTR_INIT(2'b01)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_valid(f_valid), .f_pc(f_pc),
    .p_valid(p_valid), .p_taken(p_taken), .p_target(p_target),
    .r_valid(r_valid), .r_pc(r_pc), .r_is_br(r_is_br), .r_is_call(r_is_call),
    .r_is_ret(r_is_ret), .r_taken(r_taken), .r_target(r_target),
    .r_pred_taken(r_pred_taken), .r_pred_target(r_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .mp_count(mp_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    f_valid = 1'b1;
    f_pc    = pc;
    tick();
    f_valid = 1'b0;
  endtask

  task automatic drive_res(input logic [31:0] pc, input logic br, input logic call,
                           input logic ret, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
    r_valid = 1'b1; r_pc = pc; r_is_br = br; r_is_call = call; r_is_ret = ret;
    r_taken = tk; r_target = tgt; r_pred_taken = ptk; r_pred_target = ptgt;
  endtask

  task automatic clear_res();
    r_valid = 1'b0; r_is_br = 1'b0; r_is_call = 1'b0; r_is_ret = 1'b0; r_taken = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic br, input logic call,
                         input logic ret, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    drive_res(pc, br, call, ret, tk, tgt, ptk, ptgt);
    tick();
    clear_res();
  endtask

  // Resolve whose carried prediction was correct: no flush expected.
  task automatic res_ok(input logic [31:0] pc, input logic br, input logic call,
                        input logic ret, input logic tk, input logic [31:0] tgt);
    resolve(pc, br, call, ret, tk, tgt, tk, tgt);
    check("no_flush", {31'd0, mispredict}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] tops [4];
    reset_n = 1'b0; f_valid = 1'b0; f_pc = '0;
    r_pc = '0; r_target = '0; r_pred_taken = 1'b0; r_pred_target = '0;
    clear_res();
    tick(); tick();
    check("rst_p_valid", {31'd0, p_valid}, 32'd0);
    check("rst_p_taken", {31'd0, p_taken}, 32'd0);
    check("rst_p_target", p_target, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_mp_count", {16'd0, mp_count}, 32'd0);
    reset_n = 1'b1;

    fetch(32'h100);
    check("cold_p_valid", {31'd0, p_valid}, 32'd1);
    check("cold_p_taken", {31'd0, p_taken}, 32'd0);
    check("cold_p_target", p_target, 32'h104);
    tick();
    check("idle_p_valid", {31'd0, p_valid}, 32'd0);
    check("idle_p_target", p_target, 32'd0);

    resolve(32'h100, 1, 0, 0, 1, 32'h200, 0, 32'h104);
    check("br_flush", {31'd0, mispredict}, 32'd1);
    check("br_redirect", redirect_pc, 32'h200);
    check("br_mp_count", {16'd0, mp_count}, 32'd1);
    tick();
    check("flush_pulse_end", {31'd0, mispredict}, 32'd0);
    fetch(32'h100);
    check("trained_taken", {31'd0, p_taken}, 32'd1);
    check("trained_target", p_target, 32'h200);

    // Counter 10 -> 01 -> 00 -> 00 -> 00
    for (int i = 0; i < 4; i++) begin
      resolve(32'h100, 1, 0, 0, 0, 32'h0, (i == 0), 32'h0);
      check("nt_flush", {31'd0, mispredict}, (i == 0) ? 32'd1 : 32'd0);
    end
    check("nt_mp_count", {16'd0, mp_count}, 32'd2);
    fetch(32'h100);
    check("nt_taken", {31'd0, p_taken}, 32'd0);
    check("nt_target", p_target, 32'h104);

    // Counter 00 -> 01 -> 10 -> 11 -> 11, then -> 10
    for (int i = 0; i < 4; i++) res_ok(32'h100, 1, 0, 0, 1, 32'h200);
    res_ok(32'h100, 1, 0, 0, 0, 32'h0);
    fetch(32'h100);
    check("sat_hi_taken", {31'd0, p_taken}, 32'd1);
    check("sat_hi_target", p_target, 32'h200);
    check("sat_mp_count", {16'd0, mp_count}, 32'd2);

    // Back-to-back mispredicting call and return
    resolve(32'h40, 0, 1, 0, 1, 32'h300, 0, 32'h0);
    check("call_flush", {31'd0, mispredict}, 32'd1);
    check("call_redirect", redirect_pc, 32'h300);
    resolve(32'h310, 0, 0, 1, 1, 32'h44, 0, 32'h0);
    check("ret_flush", {31'd0, mispredict}, 32'd1);
    check("ret_redirect", redirect_pc, 32'h44);
    check("ret_mp_count", {16'd0, mp_count}, 32'd4);
    fetch(32'h310);
    check("ret_empty_taken", {31'd0, p_taken}, 32'd1);
    check("ret_empty_target", p_target, 32'h44);
    res_ok(32'h80, 0, 1, 0, 1, 32'h300);
    fetch(32'h310);
    check("ret_ras_target", p_target, 32'h84);
    res_ok(32'h310, 0, 0, 1, 1, 32'h84);

    // Five nested calls into a four-deep stack: 0x24 is lost
    for (int i = 0; i < 5; i++) res_ok(32'h20 + 4 * i, 0, 1, 0, 1, 32'h700);
    tops[0] = 32'h34; tops[1] = 32'h30; tops[2] = 32'h2C; tops[3] = 32'h28;
    for (int k = 0; k < 4; k++) begin
      fetch(32'h310);
      check("lifo_target", p_target, tops[k]);
      res_ok(32'h310, 0, 0, 1, 1, tops[k]);
    end
    fetch(32'h310);
    check("lifo_empty_target", p_target, 32'h28);

    res_ok(32'h310, 0, 0, 1, 1, 32'h500);
    res_ok(32'h64, 0, 1, 0, 1, 32'h300);
    fetch(32'h310);
    check("pop_empty_push", p_target, 32'h68);
    res_ok(32'h50, 0, 1, 1, 1, 32'h700);
    fetch(32'h310);
    check("replace_top", p_target, 32'h54);
    res_ok(32'h310, 0, 0, 1, 1, 32'h800);
    fetch(32'h310);
    check("replace_cnt", p_target, 32'h800);

    // 0x200 aliases 0x100 in a 64-entry table
    res_ok(32'h200, 1, 0, 0, 1, 32'h900);
    fetch(32'h100);
    check("alias_evict_taken", {31'd0, p_taken}, 32'd0);
    check("alias_evict_target", p_target, 32'h104);
    fetch(32'h200);
    check("alias_new_taken", {31'd0, p_taken}, 32'd1);
    check("alias_new_target", p_target, 32'h900);

    drive_res(32'h200, 1, 0, 0, 1, 32'hA00, 1, 32'hA00);
    f_valid = 1'b1; f_pc = 32'h200;
    tick();
    clear_res(); f_valid = 1'b0;
    check("rbw_old_target", p_target, 32'h900);
    fetch(32'h200);
    check("rbw_new_target", p_target, 32'hA00);

    fetch(32'hFFFF_FFFC);
    check("wrap_p_target", p_target, 32'h0);
    resolve(32'hFFFF_FFFC, 1, 0, 0, 0, 32'h0, 1, 32'h0);
    check("wrap_flush", {31'd0, mispredict}, 32'd1);
    check("wrap_redirect", redirect_pc, 32'h0);
    check("wrap_mp_count", {16'd0, mp_count}, 32'd5);

    reset_n = 1'b0;
    drive_res(32'h700, 1, 0, 0, 1, 32'h900, 0, 32'h0);
    f_valid = 1'b1; f_pc = 32'h200;
    tick();
    check("mrst_mispredict", {31'd0, mispredict}, 32'd0);
    check("mrst_redirect", redirect_pc, 32'd0);
    check("mrst_mp_count", {16'd0, mp_count}, 32'd0);
    check("mrst_p_valid", {31'd0, p_valid}, 32'd0);
    check("mrst_p_target", p_target, 32'd0);
    clear_res(); f_valid = 1'b0; reset_n = 1'b1;
    tick();
    check("mrst_no_pulse", {31'd0, mispredict}, 32'd0);
    fetch(32'h200);
    check("mrst_tbl_taken", {31'd0, p_taken}, 32'd0);
    check("mrst_tbl_target", p_target, 32'h204);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
